// File: rtl/axi_protocol_checker.sv
// Passive AXI3 protocol checker: per-channel stability, burst legality,
// outstanding-burst tracking with beat counting, ID ordering and response matching.
module axi_protocol_checker #(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 4,
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic [ID_W-1:0]              AWID,
   input  logic [ADDR_W-1:0]            AWADDR,
   input  logic [LEN_W-1:0]             AWLEN,
   input  logic [2:0]                   AWSIZE,
   input  logic [1:0]                   AWBURST,
   input  logic                         AWVALID,
   input  logic                         AWREADY,
   input  logic [ID_W-1:0]              WID,
   input  logic [DATA_W-1:0]            WDATA,
   input  logic [DATA_W/8-1:0]          WSTRB,
   input  logic                         WLAST,
   input  logic                         WVALID,
   input  logic                         WREADY,
   input  logic [ID_W-1:0]              BID,
   input  logic [1:0]                   BRESP,
   input  logic                         BVALID,
   input  logic                         BREADY,
   input  logic [ID_W-1:0]              ARID,
   input  logic [ADDR_W-1:0]            ARADDR,
   input  logic [LEN_W-1:0]             ARLEN,
   input  logic [2:0]                   ARSIZE,
   input  logic [1:0]                   ARBURST,
   input  logic                         ARVALID,
   input  logic                         ARREADY,
   input  logic [ID_W-1:0]              RID,
   input  logic [DATA_W-1:0]            RDATA,
   input  logic [1:0]                   RRESP,
   input  logic                         RLAST,
   input  logic                         RVALID,
   input  logic                         RREADY,
   input  logic                         clr_err,
   output logic [11:0]                  err_sticky,
   output logic                         err_pulse,
   output logic [CNT_W-1:0]             wr_done_cnt,
   output logic [CNT_W-1:0]             rd_done_cnt,
   output logic [$clog2(MAX_OUTST):0]   wr_outst,
   output logic [$clog2(MAX_OUTST):0]   rd_outst
);
   localparam int PW  = $clog2(MAX_OUTST) + 1;
   localparam int IW  = PW - 1;
   localparam int AXP = ID_W + ADDR_W + LEN_W + 5;
   localparam int WP  = ID_W + DATA_W + DATA_W/8 + 1;
   localparam int BP  = ID_W + 2;
   localparam int RP  = ID_W + DATA_W + 3;

   function automatic logic bad_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                                      input logic [2:0] s, input logic [1:0] b);
      logic [ADDR_W-1:0] mask;
      logic              wrap_len_ok;
      mask        = ADDR_W'((32'd1 << s) - 32'd1);
      wrap_len_ok = (l == LEN_W'(1)) || (l == LEN_W'(3)) || (l == LEN_W'(7)) || (l == LEN_W'(15));
      bad_burst   = (b == 2'b11) || ((32'd1 << s) > 32'(DATA_W/8)) ||
                    ((b == 2'b10) && !wrap_len_ok) || ((b == 2'b10) && ((a & mask) != '0));
   endfunction

   logic [AXP-1:0] aw_pay, aw_pay_q, ar_pay, ar_pay_q;
   logic [WP-1:0]  w_pay, w_pay_q;
   logic [BP-1:0]  b_pay, b_pay_q;
   logic [RP-1:0]  r_pay, r_pay_q;
   logic           aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q;

   assign aw_pay = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
   assign ar_pay = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
   assign w_pay  = {WID, WDATA, WSTRB, WLAST};
   assign b_pay  = {BID, BRESP};
   assign r_pay  = {RID, RDATA, RRESP, RLAST};

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   // Write queue has three pointers: push, data head, and response head.
   logic [ID_W-1:0]  wq_id [MAX_OUTST];
   logic [LEN_W-1:0] wq_len [MAX_OUTST];
   logic [ID_W-1:0]  rq_id [MAX_OUTST];
   logic [LEN_W-1:0] rq_len [MAX_OUTST];
   logic [PW-1:0]    wq_wr, wq_dp, wq_bp, rq_wr, rq_rd;
   logic [LEN_W-1:0] wbeat, rbeat;

   logic [PW-1:0]    w_wait, w_comp;
   logic             b_pop, aw_push, w_has_head, w_last_beat, r_last_beat, r_pop, ar_push;
   logic [ID_W-1:0]  w_head_id, r_head_id;
   logic [LEN_W-1:0] w_head_len, r_head_len;
   logic [11:0]      err_now;

   assign wr_outst = wq_wr - wq_bp;
   assign rd_outst = rq_wr - rq_rd;
   assign w_wait   = wq_wr - wq_dp;
   assign w_comp   = wq_dp - wq_bp;

   always_comb begin
      b_pop      = b_hs && (w_comp != '0);
      aw_push    = aw_hs && ((wr_outst != PW'(MAX_OUTST)) || b_pop);
      w_has_head = (w_wait != '0) || aw_push;
      // With nothing awaiting data, a same-edge AW supplies the head entry.
      w_head_id   = (w_wait != '0) ? wq_id[wq_dp[IW-1:0]]  : AWID;
      w_head_len  = (w_wait != '0) ? wq_len[wq_dp[IW-1:0]] : AWLEN;
      w_last_beat = (wbeat == w_head_len);
      r_head_id   = rq_id[rq_rd[IW-1:0]];
      r_head_len  = rq_len[rq_rd[IW-1:0]];
      r_last_beat = (rbeat == r_head_len);
      r_pop       = r_hs && (rd_outst != '0) && r_last_beat;
      ar_push     = ar_hs && ((rd_outst != PW'(MAX_OUTST)) || r_pop);

      err_now     = '0;
      err_now[0]  = aw_stall_q && (!AWVALID || (aw_pay != aw_pay_q));
      err_now[1]  = w_stall_q  && (!WVALID  || (w_pay  != w_pay_q));
      err_now[2]  = b_stall_q  && (!BVALID  || (b_pay  != b_pay_q));
      err_now[3]  = ar_stall_q && (!ARVALID || (ar_pay != ar_pay_q));
      err_now[4]  = r_stall_q  && (!RVALID  || (r_pay  != r_pay_q));
      err_now[5]  = aw_hs && bad_burst(AWADDR, AWLEN, AWSIZE, AWBURST);
      err_now[6]  = ar_hs && bad_burst(ARADDR, ARLEN, ARSIZE, ARBURST);
      err_now[7]  = w_hs && (!w_has_head || (WLAST != w_last_beat) || (WID != w_head_id));
      err_now[8]  = r_hs && (rd_outst != '0) && (RLAST != r_last_beat);
      err_now[9]  = b_hs && ((w_comp == '0) || (BID != wq_id[wq_bp[IW-1:0]]));
      err_now[10] = r_hs && ((rd_outst == '0) || (RID != r_head_id));
      err_now[11] = (aw_hs && !aw_push) || (ar_hs && !ar_push);
   end

   // Queue payload storage carries no reset; pointers define validity.
   always_ff @(posedge ACLK) begin
      if (aw_push) begin
         wq_id[wq_wr[IW-1:0]]  <= AWID;
         wq_len[wq_wr[IW-1:0]] <= AWLEN;
      end
      if (ar_push) begin
         rq_id[rq_wr[IW-1:0]]  <= ARID;
         rq_len[rq_wr[IW-1:0]] <= ARLEN;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wq_wr <= '0; wq_dp <= '0; wq_bp <= '0; rq_wr <= '0; rq_rd <= '0;
         wbeat <= '0; rbeat <= '0;
         aw_stall_q <= 1'b0; w_stall_q <= 1'b0; b_stall_q <= 1'b0;
         ar_stall_q <= 1'b0; r_stall_q <= 1'b0;
         aw_pay_q <= '0; w_pay_q <= '0; b_pay_q <= '0; ar_pay_q <= '0; r_pay_q <= '0;
         err_sticky  <= '0;
         err_pulse   <= 1'b0;
         wr_done_cnt <= '0;
         rd_done_cnt <= '0;
      end else begin
         aw_stall_q <= AWVALID && !AWREADY;
         w_stall_q  <= WVALID && !WREADY;
         b_stall_q  <= BVALID && !BREADY;
         ar_stall_q <= ARVALID && !ARREADY;
         r_stall_q  <= RVALID && !RREADY;
         aw_pay_q <= aw_pay; w_pay_q <= w_pay; b_pay_q <= b_pay;
         ar_pay_q <= ar_pay; r_pay_q <= r_pay;

         if (aw_push) wq_wr <= wq_wr + 1'b1;
         if (ar_push) rq_wr <= rq_wr + 1'b1;
         if (b_pop)   wq_bp <= wq_bp + 1'b1;
         if (w_hs && w_has_head) begin
            if (w_last_beat) begin
               wq_dp <= wq_dp + 1'b1;
               wbeat <= '0;
            end else begin
               wbeat <= wbeat + 1'b1;
            end
         end
         if (r_hs && (rd_outst != '0)) begin
            if (r_last_beat) begin
               rq_rd <= rq_rd + 1'b1;
               rbeat <= '0;
            end else begin
               rbeat <= rbeat + 1'b1;
            end
         end

         if (b_hs && (wr_done_cnt != '1)) wr_done_cnt <= wr_done_cnt + 1'b1;
         if (r_pop && (rd_done_cnt != '1)) rd_done_cnt <= rd_done_cnt + 1'b1;

         // A violation on the clearing edge survives the clear.
         err_sticky <= clr_err ? err_now : (err_sticky | err_now);
         err_pulse  <= |(err_now & (clr_err ? 12'hfff : ~err_sticky));
      end
   end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker with hand-computed expectations.
module tb_axi_protocol_checker;
   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [3:0]  AWID, WID, BID, ARID, RID;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [3:0]  AWLEN, ARLEN, WSTRB;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, clr_err;
   logic [11:0] err_sticky;
   logic        err_pulse;
   logic [15:0] wr_done_cnt, rd_done_cnt;
   logic [2:0]  wr_outst, rd_outst;

   int total = 0;
   int bad   = 0;

   always #5 ACLK = ~ACLK;

   axi_protocol_checker dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .clr_err(clr_err), .err_sticky(err_sticky), .err_pulse(err_pulse),
      .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
      .wr_outst(wr_outst), .rd_outst(rd_outst)
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hs_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
      AWVALID = 1'b1; AWREADY = 1'b1;
      tick();
      AWVALID = 1'b0; AWREADY = 1'b0;
   endtask

   task automatic hs_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1; ARREADY = 1'b1;
      tick();
      ARVALID = 1'b0; ARREADY = 1'b0;
   endtask

   task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
      WID = id; WDATA = data; WSTRB = 4'hf; WLAST = last; WVALID = 1'b1; WREADY = 1'b1;
      tick();
      WVALID = 1'b0; WREADY = 1'b0;
   endtask

   task automatic b_beat(input logic [3:0] id);
      BID = id; BRESP = 2'b00; BVALID = 1'b1; BREADY = 1'b1;
      tick();
      BVALID = 1'b0; BREADY = 1'b0;
   endtask

   task automatic r_beat(input logic [3:0] id, input logic last);
      RID = id; RDATA = $urandom_range(0, 32'hffff); RRESP = 2'b00; RLAST = last;
      RVALID = 1'b1; RREADY = 1'b1;
      tick();
      RVALID = 1'b0; RREADY = 1'b0;
   endtask

   task automatic clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      ARESETn = 1'b0; clr_err = 1'b0;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0; AWREADY = 1'b0;
      WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; WREADY = 1'b0;
      BID = '0; BRESP = '0; BVALID = 1'b0; BREADY = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; ARREADY = 1'b0;
      RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0; RREADY = 1'b0;
      tick(); tick();
      chk("rst_sticky", 32'(err_sticky), 32'h0);
      chk("rst_pulse", 32'(err_pulse), 32'h0);
      chk("rst_wr_done", 32'(wr_done_cnt), 32'h0);
      chk("rst_rd_done", 32'(rd_done_cnt), 32'h0);
      chk("rst_wr_outst", 32'(wr_outst), 32'h0);
      chk("rst_rd_outst", 32'(rd_outst), 32'h0);
      ARESETn = 1'b1;
      tick();

      // Legal INCR write, 4 beats.
      hs_aw(4'd3, 32'h1000, 4'd3, 3'd2, 2'b01);
      chk("wr1_outst_after_aw", 32'(wr_outst), 32'd1);
      for (int i = 0; i < 4; i++) w_beat(4'd3, 32'(i), (i == 3));
      chk("wr1_err_after_w", 32'(err_sticky), 32'h0);
      chk("wr1_outst_after_w", 32'(wr_outst), 32'd1);
      b_beat(4'd3);
      chk("wr1_done", 32'(wr_done_cnt), 32'd1);
      chk("wr1_outst_after_b", 32'(wr_outst), 32'd0);
      chk("wr1_err_final", 32'(err_sticky), 32'h0);

      // AW payload change while stalled.
      AWID = 4'd1; AWADDR = 32'h100; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
      AWVALID = 1'b1; AWREADY = 1'b0;
      tick();
      AWADDR = 32'h104;
      tick();
      chk("stab_sticky", 32'(err_sticky), 32'h001);
      chk("stab_pulse_hi", 32'(err_pulse), 32'd1);
      AWREADY = 1'b1;
      tick();
      AWVALID = 1'b0; AWREADY = 1'b0;
      chk("stab_pulse_lo", 32'(err_pulse), 32'd0);
      chk("stab_sticky_held", 32'(err_sticky), 32'h001);
      chk("stab_outst", 32'(wr_outst), 32'd1);
      clr();
      chk("clr_sticky", 32'(err_sticky), 32'h0);
      w_beat(4'd1, 32'hab, 1'b1);
      b_beat(4'd1);
      chk("stab_wr_done", 32'(wr_done_cnt), 32'd2);
      chk("stab_err_final", 32'(err_sticky), 32'h0);

      // AW and its only W beat on the same edge.
      AWID = 4'd4; AWADDR = 32'h2000; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
      AWVALID = 1'b1; AWREADY = 1'b1;
      WID = 4'd4; WDATA = 32'h55; WSTRB = 4'hf; WLAST = 1'b1; WVALID = 1'b1; WREADY = 1'b1;
      tick();
      AWVALID = 1'b0; AWREADY = 1'b0; WVALID = 1'b0; WREADY = 1'b0;
      chk("same_edge_err", 32'(err_sticky), 32'h0);
      b_beat(4'd4);
      chk("same_edge_done", 32'(wr_done_cnt), 32'd3);
      chk("same_edge_err_b", 32'(err_sticky), 32'h0);

      // Illegal bursts and read queue overflow.
      hs_ar(4'd0, 32'h0, 4'd2, 3'd2, 2'b10);
      chk("ar_wrap_len2", 32'(err_sticky), 32'h040);
      clr();
      hs_ar(4'd0, 32'h102, 4'd3, 3'd2, 2'b10);
      chk("ar_wrap_unaligned", 32'(err_sticky), 32'h040);
      clr();
      hs_ar(4'd0, 32'h100, 4'd3, 3'd2, 2'b10);
      chk("ar_wrap_legal", 32'(err_sticky), 32'h0);
      chk("ar_outst_3", 32'(rd_outst), 32'd3);
      hs_aw(4'd6, 32'h300, 4'd0, 3'd2, 2'b11);
      chk("aw_burst3", 32'(err_sticky), 32'h020);
      clr();
      hs_ar(4'd0, 32'h400, 4'd0, 3'd3, 2'b01);
      chk("ar_size_too_big", 32'(err_sticky), 32'h040);
      chk("ar_outst_4", 32'(rd_outst), 32'd4);
      clr();
      clr_err = 1'b1;
      hs_ar(4'd7, 32'h500, 4'd0, 3'd2, 2'b01);
      clr_err = 1'b0;
      chk("ar_overflow_set_wins", 32'(err_sticky), 32'h800);
      chk("ar_overflow_pulse", 32'(err_pulse), 32'd1);
      chk("ar_overflow_outst", 32'(rd_outst), 32'd4);
      clr();
      b_beat(4'd6);
      chk("b_no_complete", 32'(err_sticky), 32'h200);

      // Reset in the middle of a burst.
      hs_aw(4'd2, 32'h600, 4'd3, 3'd2, 2'b01);
      w_beat(4'd2, 32'h1, 1'b0);
      w_beat(4'd2, 32'h2, 1'b0);
      chk("pre_rst_rd_outst", 32'(rd_outst), 32'd4);
      ARESETn = 1'b0;
      #1;
      chk("async_rst_sticky", 32'(err_sticky), 32'h0);
      chk("async_rst_wr_outst", 32'(wr_outst), 32'd0);
      chk("async_rst_rd_outst", 32'(rd_outst), 32'd0);
      chk("async_rst_wr_done", 32'(wr_done_cnt), 32'd0);
      tick();
      ARESETn = 1'b1;
      tick();
      hs_aw(4'd2, 32'h600, 4'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(4'd2, 32'(i + 8), (i == 3));
      b_beat(4'd2);
      chk("post_rst_err", 32'(err_sticky), 32'h0);
      chk("post_rst_wr_done", 32'(wr_done_cnt), 32'd1);
      chk("post_rst_wr_outst", 32'(wr_outst), 32'd0);

      // Read with RLAST on the wrong beat; pop still follows ARLEN.
      hs_ar(4'd5, 32'h200, 4'd3, 3'd2, 2'b01);
      chk("rd_outst_1", 32'(rd_outst), 32'd1);
      for (int i = 0; i < 3; i++) r_beat(4'd5, (i == 1));
      chk("rlast_early_err", 32'(err_sticky), 32'h100);
      chk("rd_outst_mid", 32'(rd_outst), 32'd1);
      r_beat(4'd5, 1'b0);
      chk("rd_pop_outst", 32'(rd_outst), 32'd0);
      chk("rd_done", 32'(rd_done_cnt), 32'd1);
      chk("rlast_err_final", 32'(err_sticky), 32'h100);
      clr();
      r_beat(4'd5, 1'b1);
      chk("r_empty_queue", 32'(err_sticky), 32'h400);
      chk("r_empty_done", 32'(rd_done_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
